// File: rtl/satd_pkg.sv
// Shared SATD datapath defaults and width helpers.
package satd_pkg;

    localparam int unsigned N_DEF        = 8;
    localparam int unsigned ROWS_DEF     = 8;
    localparam int unsigned BITDEPTH_DEF = 8;

    // Block SAD width: enough for N*ROWS samples at full-scale magnitude.
    function automatic int unsigned sad_width(input int unsigned bitdepth,
                                               input int unsigned n,
                                               input int unsigned rows);
        return bitdepth + $clog2(n * rows);
    endfunction

    localparam int unsigned PIX_W    = BITDEPTH_DEF;
    localparam int unsigned DIFF_W   = BITDEPTH_DEF + 1;
    localparam int unsigned SADW_DEF = sad_width(BITDEPTH_DEF, N_DEF, ROWS_DEF);

endpackage

// File: rtl/satd_residual_stage_if.sv
// Pixel-row input stream and residual-row output stream of the residual stage.
interface satd_residual_stage_if
    import satd_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned ROWS     = ROWS_DEF,
    parameter int unsigned BITDEPTH = BITDEPTH_DEF
);
    localparam int unsigned SADW = sad_width(BITDEPTH, N, ROWS);

    logic                          in_valid;
    logic                          in_ready;
    logic [N*BITDEPTH-1:0]         org_row;
    logic [N*BITDEPTH-1:0]         cur_row;
    logic                          out_valid;
    logic                          out_ready;
    logic [N*(BITDEPTH+1)-1:0]     diff_row;
    logic [$clog2(ROWS)-1:0]       out_row_idx;
    logic                          out_last;
    logic [SADW-1:0]               blk_sad;

    modport master (
        output in_valid, org_row, cur_row, out_ready,
        input  in_ready, out_valid, diff_row, out_row_idx, out_last, blk_sad
    );

    modport slave (
        input  in_valid, org_row, cur_row, out_ready,
        output in_ready, out_valid, diff_row, out_row_idx, out_last, blk_sad
    );

endinterface

// File: rtl/satd_abs_sum.sv
// Combinational sum of absolute values of N signed differences via a binary adder tree.
module satd_abs_sum
    import satd_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned BITDEPTH = BITDEPTH_DEF,
    parameter int unsigned SADW     = SADW_DEF
) (
    input  logic [N*(BITDEPTH+1)-1:0] diff_row,
    output logic [SADW-1:0]           abs_sum
);
    localparam int unsigned DW     = BITDEPTH + 1;
    localparam int unsigned LEAVES = 1 << $clog2(N);

    // Heap-ordered tree: node[1] is the root, leaves sit at LEAVES..2*LEAVES-1.
    logic [SADW-1:0] node [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < N) begin : g_used
            logic [DW-1:0] d;
            logic [DW-1:0] mag;
            assign d   = diff_row[i*DW +: DW];
            assign mag = d[DW-1] ? (~d + 1'b1) : d;
            assign node[LEAVES+i] = {{(SADW-DW){1'b0}}, mag};
        end else begin : g_pad
            assign node[LEAVES+i] = '0;
        end
    end

    for (genvar j = 1; j < LEAVES; j++) begin : g_node
        assign node[j] = node[2*j] + node[2*j+1];
    end

    assign abs_sum = node[1];

endmodule

// File: rtl/satd_residual_stage.sv
// Registered residual stage: per-row org-cur differences, row index and running block SAD.
module satd_residual_stage
    import satd_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned ROWS     = ROWS_DEF,
    parameter int unsigned BITDEPTH = BITDEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    satd_residual_stage_if.slave s
);
    localparam int unsigned DW   = BITDEPTH + 1;
    localparam int unsigned SADW = sad_width(BITDEPTH, N, ROWS);
    localparam int unsigned IW   = $clog2(ROWS);

    logic              accept;
    logic              emit;
    logic              in_ready;
    logic [N*DW-1:0]   diff_now;
    logic [SADW-1:0]   row_abs;

    logic              out_valid_q,   out_valid_d;
    logic [N*DW-1:0]   diff_row_q,    diff_row_d;
    logic [IW-1:0]     out_row_idx_q, out_row_idx_d;
    logic              out_last_q,    out_last_d;
    logic [SADW-1:0]   blk_sad_q,     blk_sad_d;
    logic [IW-1:0]     row_cnt_q,     row_cnt_d;

    for (genvar i = 0; i < N; i++) begin : g_diff
        assign diff_now[i*DW +: DW] = {1'b0, s.org_row[i*BITDEPTH +: BITDEPTH]}
                                    - {1'b0, s.cur_row[i*BITDEPTH +: BITDEPTH]};
    end

    satd_abs_sum #(
        .N        (N),
        .BITDEPTH (BITDEPTH),
        .SADW     (SADW)
    ) u_abs_sum (
        .diff_row (diff_now),
        .abs_sum  (row_abs)
    );

    assign in_ready = !out_valid_q || s.out_ready;
    assign accept   = s.in_valid && in_ready;
    assign emit     = out_valid_q && s.out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        diff_row_d    = diff_row_q;
        out_row_idx_d = out_row_idx_q;
        out_last_d    = out_last_q;
        blk_sad_d     = blk_sad_q;
        row_cnt_d     = row_cnt_q;
        if (accept) begin
            // Accept wins over emit: a concurrent emit simply hands the slot to the new beat.
            out_valid_d   = 1'b1;
            diff_row_d    = diff_now;
            out_row_idx_d = row_cnt_q;
            out_last_d    = (row_cnt_q == IW'(ROWS - 1));
            blk_sad_d     = (row_cnt_q == '0) ? row_abs : blk_sad_q + row_abs;
            row_cnt_d     = row_cnt_q + 1'b1;
        end else if (emit) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            diff_row_q    <= '0;
            out_row_idx_q <= '0;
            out_last_q    <= 1'b0;
            blk_sad_q     <= '0;
            row_cnt_q     <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            diff_row_q    <= diff_row_d;
            out_row_idx_q <= out_row_idx_d;
            out_last_q    <= out_last_d;
            blk_sad_q     <= blk_sad_d;
            row_cnt_q     <= row_cnt_d;
        end
    end

    assign s.in_ready    = in_ready;
    assign s.out_valid   = out_valid_q;
    assign s.diff_row    = diff_row_q;
    assign s.out_row_idx = out_row_idx_q;
    assign s.out_last    = out_last_q;
    assign s.blk_sad     = blk_sad_q;

endmodule
